// File: rtl/uart_operand_link.sv
// ---------------------------------------------------------------------------
// uart_operand_link
//
// A UART link that connects the host serial line to the peripheral bank.
//   RX: receives two 8N1 bytes on din, presents them as operands a/b, and
//       raises ready once a complete pair has arrived.
//   TX: sends the 8-bit result as one 8N1 frame on dout each time tx_en
//       rises. tx_en and result are registers in the CPU clock domain.
//
// Ports
//   clk      in   peripheral clock
//   reset_n  in   asynchronous active-low reset
//   din      in   serial RX line, idle high, asynchronous
//   result   in   [7:0] byte to transmit, stable while tx_en is high
//   tx_en    in   transmit request level; each rising edge sends one frame
//   dout     out  serial TX line, idle high
//   a        out  [7:0] first byte of the last complete pair
//   b        out  [7:0] second byte of the last complete pair
//   ready    out  a/b hold a fresh, complete pair
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (4..65535)
//   SYNC_STAGES   synchroniser depth for din and tx_en (2..3)
// ---------------------------------------------------------------------------
module uart_operand_link #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       din,
    input  logic [7:0] result,
    input  logic       tx_en,
    output logic       dout,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Down-counter reload values. RX waits half a bit after the falling edge
    // so every later sample lands mid-bit.
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

    // -----------------------------------------------------------------------
    // Synchronisers
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_tx_en_sync;
    logic                   r_tx_en_prev;
    logic                   w_din_s;
    logic                   w_tx_s;
    logic                   w_tx_rise;

    // NOTE: the din chain resets to 1 (line idle); resetting it to 0 would
    // look like a start bit on the first cycle after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_din_sync   <= '1;
            r_tx_en_sync <= '0;
            r_tx_en_prev <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_din_sync   <= {r_din_sync[SYNC_STAGES-2:0], din};
            r_tx_en_sync <= {r_tx_en_sync[SYNC_STAGES-2:0], tx_en};
            r_tx_en_prev <= w_tx_s;
        end
    end

    assign w_din_s   = r_din_sync[SYNC_STAGES-1];
    assign w_tx_s    = r_tx_en_sync[SYNC_STAGES-1];
    assign w_tx_rise = w_tx_s & ~r_tx_en_prev;

    // -----------------------------------------------------------------------
    // RX path
    // -----------------------------------------------------------------------
    uart_state_t r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_cnt,   w_rx_cnt_nxt;
    logic [2:0]  r_rx_bit,   w_rx_bit_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic [7:0]  r_a,        w_a_nxt;
    logic [7:0]  r_b,        w_b_nxt;
    logic        r_idx,      w_idx_nxt;
    logic        r_ready,    w_ready_nxt;
    logic        w_first_done;
    logic        w_pair_done;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_idx_nxt      = r_idx;
        w_first_done   = 1'b0;
        w_pair_done    = 1'b0;

        case (r_rx_state)
            ST_IDLE: begin
                if (!w_din_s) begin
                    w_rx_cnt_nxt   = HALF_M1;
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_rx_cnt == 16'd0) begin
                    if (w_din_s) begin
                        // Line went back high before mid-bit: glitch.
                        w_rx_state_nxt = ST_IDLE;
                    end else begin
                        w_rx_cnt_nxt   = FULL_M1;
                        w_rx_bit_nxt   = 3'd0;
                        w_rx_state_nxt = ST_DATA;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == 16'd0) begin
                    // LSB arrives first, so shift in from the top.
                    w_rx_shift_nxt = {w_din_s, r_rx_shift[7:1]};
                    w_rx_cnt_nxt   = FULL_M1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = ST_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == 16'd0) begin
                    // Leaving at mid-stop lets a back-to-back start bit be
                    // seen on the very next cycle.
                    w_rx_state_nxt = ST_IDLE;
                    if (w_din_s) begin
                        if (!r_idx) begin
                            w_a_nxt      = r_rx_shift;
                            w_idx_nxt    = 1'b1;
                            w_first_done = 1'b1;
                        end else begin
                            w_b_nxt     = r_rx_shift;
                            w_idx_nxt   = 1'b0;
                            w_pair_done = 1'b1;
                        end
                    end
                    // Stop bit low: framing error, byte dropped silently.
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end
            end
            default: w_rx_state_nxt = ST_IDLE;
        endcase
    end

    // A completed pair wins over a simultaneous tx_en rise; otherwise the
    // first byte of a new pair or any tx_en rise retires the old pair.
    always_comb begin
        w_ready_nxt = r_ready;
        if (w_pair_done) begin
            w_ready_nxt = 1'b1;
        end else if (w_first_done || w_tx_rise) begin
            w_ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_idx      <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_idx      <= w_idx_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // TX path
    // -----------------------------------------------------------------------
    uart_state_t r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_cnt,   w_tx_cnt_nxt;
    logic [2:0]  r_tx_bit,   w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic        r_dout,     w_dout_nxt;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_dout_nxt     = r_dout;

        case (r_tx_state)
            ST_IDLE: begin
                w_dout_nxt = 1'b1;
                // Rises seen in any other state are dropped, not queued.
                if (w_tx_rise) begin
                    w_tx_shift_nxt = result;
                    w_dout_nxt     = 1'b0;
                    w_tx_cnt_nxt   = FULL_M1;
                    w_tx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_tx_cnt == 16'd0) begin
                    w_dout_nxt     = r_tx_shift[0];
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_cnt_nxt   = FULL_M1;
                    w_tx_state_nxt = ST_DATA;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_cnt_nxt = FULL_M1;
                    if (r_tx_bit == 3'd7) begin
                        w_dout_nxt     = 1'b1;
                        w_tx_state_nxt = ST_STOP;
                    end else begin
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_dout_nxt     = r_tx_shift[1];
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_state_nxt = ST_IDLE;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            default: begin
                w_dout_nxt     = 1'b1;
                w_tx_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_dout     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_dout     <= w_dout_nxt;
        end
    end

    assign dout  = r_dout;
    assign a     = r_a;
    assign b     = r_b;
    assign ready = r_ready;

endmodule

// File: tb/tb_uart_operand_link.sv
// ---------------------------------------------------------------------------
// Testbench for uart_operand_link (CLKS_PER_BIT=16, SYNC_STAGES=2).
// The reference model tracks the operand pair at frame level: each valid
// frame fills a then b, a bad stop bit drops the byte, a tx_en rise clears
// ready. TX frames are checked bit-window by bit-window against 8N1.
// ---------------------------------------------------------------------------
module tb_uart_operand_link;

    localparam int CPB  = 16;
    localparam int SYNC = 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       din     = 1'b1;
    logic [7:0] result  = 8'd0;
    logic       tx_en   = 1'b0;
    logic       dout;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model of the operand pair.
    logic [7:0] m_a     = 8'd0;
    logic [7:0] m_b     = 8'd0;
    logic       m_idx   = 1'b0;
    logic       m_ready = 1'b0;

    uart_operand_link #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (din),
        .result (result),
        .tx_en  (tx_en),
        .dout   (dout),
        .a      (a),
        .b      (b),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------------------- helpers
    task automatic drive_bit(input logic v);
        din = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Send one 8N1 frame, idle for gap cycles, then update the model.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        din = 1'b1;
        repeat (gap) @(negedge clk);
        if (stop_ok) begin
            if (!m_idx) begin
                m_a = d; m_idx = 1'b1; m_ready = 1'b0;
            end else begin
                m_b = d; m_idx = 1'b0; m_ready = 1'b1;
            end
        end
    endtask

    // Wait for a start bit, then check all ten 16-cycle windows of the frame
    // and that the line stays idle for idle_after cycles afterwards.
    task automatic tx_check(input string name, input logic [7:0] d, input int idle_after);
        logic samples [160];
        int   waited;
        logic exp_v;
        logic got_v;
        logic ok;
        waited = 0;
        while (dout !== 1'b0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 40) begin
            errors++;
            $display("FAIL %s start: dout=%b after %0d cycles, required 0", name, dout, waited);
            return;
        end
        for (int i = 0; i < 160; i++) begin
            samples[i] = dout;
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            exp_v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            ok    = 1'b1;
            got_v = exp_v;
            for (int j = 0; j < CPB; j++) begin
                if (samples[k*CPB+j] !== exp_v) begin
                    ok    = 1'b0;
                    got_v = samples[k*CPB+j];
                end
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s bit window %0d: dout=%b, required %b", name, k, got_v, exp_v);
            end
        end
        ok = 1'b1;
        for (int i = 0; i < idle_after; i++) begin
            if (dout !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s idle after frame: dout=0 seen, required 1", name);
        end
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 1'b1) begin
            errors++;
            $display("FAIL reset dout: dout=%b, required 1", dout);
        end
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL reset rx: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rx_pair();
        send_frame(8'h35, 1'b1, 0);
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL rx_first_byte: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
        send_frame(8'hA2, 1'b1, 4);
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL rx_pair: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
    endtask

    task automatic test_tx_5c();
        result = 8'h5C;
        fork
            tx_check("tx_5c", 8'h5C, 20);
            begin
                tx_en = 1'b1;
                m_ready = 1'b0;
                repeat (5) @(negedge clk);
                checks++;
                if (ready !== m_ready) begin
                    errors++;
                    $display("FAIL ready_clear_on_tx: ready=%b, required %b", ready, m_ready);
                end
                repeat (35) @(negedge clk);
                tx_en = 1'b0;
            end
        join
    endtask

    task automatic test_tx_latency();
        logic [7:0] r;
        r = 8'($urandom);
        result = r;
        tx_en = 1'b1;
        m_ready = 1'b0;
        repeat (SYNC) @(negedge clk);
        checks++;
        if (dout !== 1'b1) begin
            errors++;
            $display("FAIL tx_latency early: dout=%b, required 1", dout);
        end
        @(negedge clk);
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL tx_latency start: dout=%b, required 0", dout);
        end
        repeat (170) @(negedge clk);
        tx_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_framing();
        send_frame(8'h11, 1'b0, 32);
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL framing_discard: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
        send_frame(8'h22, 1'b1, 0);
        send_frame(8'h33, 1'b1, 4);
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL framing_recover: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
    endtask

    task automatic test_glitch();
        din = 1'b0;
        repeat (5) @(negedge clk);
        din = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL glitch_ignored: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
        send_frame(8'($urandom), 1'b1, 0);
        send_frame(8'($urandom), 1'b1, 2);
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL glitch_then_pair: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        logic       ok;
        for (int n = 0; n < 6; n++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, ok ? int'($urandom_range(0, 3)) : 32);
            checks++;
            if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
                errors++;
                $display("FAIL random_frame %0d (d=%h stop=%b): a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                         n, d, ok, a, b, ready, m_a, m_b, m_ready);
            end
        end
    endtask

    task automatic test_duplex();
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 8'($urandom);
        x = 8'($urandom_range(1, 255));
        y = 8'($urandom_range(1, 255));
        result = r;
        fork
            tx_check("tx_duplex", r, 60);
            begin
                tx_en = 1'b1;
                m_ready = 1'b0;
                repeat (20) @(negedge clk);
                result = ~r;  // must not disturb the latched frame
                repeat (30) @(negedge clk);
                tx_en = 1'b0;
                @(negedge clk);
                tx_en = 1'b1;  // rise while busy: ignored by TX
                m_ready = 1'b0;
                repeat (10) @(negedge clk);
                tx_en = 1'b0;
            end
            begin
                send_frame(x, 1'b1, 0);
                send_frame(y, 1'b1, 2);
                checks++;
                if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
                    errors++;
                    $display("FAIL duplex_rx: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                             a, b, ready, m_a, m_b, m_ready);
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r;
        logic [7:0] x;
        logic [9:0] f;
        // Bit 3 is on the line when reset hits, so force it low.
        r = 8'($urandom) & 8'hF7;
        x = 8'($urandom);
        f = {1'b1, x, 1'b0};
        result = r;
        tx_en = 1'b1;
        m_ready = 1'b0;
        for (int c = 0; c < 70; c++) begin
            din = f[c / CPB];
            @(negedge clk);
        end
        reset_n = 1'b0;
        m_a = 8'd0; m_b = 8'd0; m_idx = 1'b0; m_ready = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid dout: dout=%b, required 1", dout);
        end
        checks++;
        if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
            errors++;
            $display("FAIL reset_mid rx: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                     a, b, ready, m_a, m_b, m_ready);
        end
        tx_en = 1'b0;
        din   = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        r = 8'($urandom);
        result = r;
        fork
            tx_check("tx_after_reset", r, 10);
            begin
                tx_en = 1'b1;
                m_ready = 1'b0;
                repeat (20) @(negedge clk);
                tx_en = 1'b0;
            end
            begin
                send_frame(8'($urandom), 1'b1, 0);
                send_frame(8'($urandom), 1'b1, 2);
                checks++;
                if ({a, b, ready} !== {m_a, m_b, m_ready}) begin
                    errors++;
                    $display("FAIL rx_after_reset: a=%h b=%h ready=%b, required a=%h b=%h ready=%b",
                             a, b, ready, m_a, m_b, m_ready);
                end
            end
        join
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rx_pair();
        test_tx_5c();
        test_tx_latency();
        test_framing();
        test_glitch();
        test_random_frames();
        test_duplex();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
